// File: rtl/relu_act_pipe.sv
// relu_act_pipe: multi-lane, two-stage fixed-point activation unit with
// valid/ready flow control. Placed between the MAC accumulator output and the
// next layer's input buffer.
//   Stage 1 applies the per-beat mode to every IN_W lane:
//     00 bypass, 01 ReLU, 10 ReLU6 (clamp at THRESHOLD), 11 leaky ReLU.
//   Stage 2 rescales each lane to OUT_W by an arithmetic right shift of SHIFT
//     bits and saturates the result.
//   clip_cnt counts lanes hit by the ReLU6 top clamp or by output saturation.
//
// Build option: define RELU_ROUND_EN for round-half-up rescaling. With the
// macro undefined, the rescale truncates. Ports and latency are the same in
// both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   in_valid   in   input beat valid
//   in_ready   out  unit can accept a beat (combinational, = advance)
//   in_mode    in   [1:0] activation mode, sampled with the beat
//   in_data    in   [LANES*IN_W-1:0] packed signed lanes, lane 0 in LSBs
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the beat
//   out_data   out  [LANES*OUT_W-1:0] packed signed results, lane 0 in LSBs
//   clip_cnt   out  [CNT_W-1:0] saturating clip event counter
//   clr_cnt    in   synchronous clear of clip_cnt (wins over increment)
module relu_act_pipe #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FRAC_IN    = 15,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned THRESHOLD  = 6,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [LANES*IN_W-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic [CNT_W-1:0]         clip_cnt,
  input  logic                     clr_cnt
);

  // Stage-2 arithmetic is one bit wider so that the rounding add cannot wrap.
  localparam int unsigned SW  = IN_W + 1;
  localparam int unsigned CW1 = CNT_W + 1;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_RELU   = 2'b01;
  localparam logic [1:0] MODE_RELU6  = 2'b10;
  localparam logic [1:0] MODE_LEAKY  = 2'b11;

  localparam logic signed [IN_W-1:0] T_FXP   = IN_W'(THRESHOLD << FRAC_IN);
  localparam logic signed [SW-1:0]   OUT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0]   OUT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CW1-1:0]         CNT_MAX = {1'b0, {CNT_W{1'b1}}};
`ifdef RELU_ROUND_EN
  localparam logic signed [SW-1:0]   RND     = SW'(1) << (SHIFT - 1);
`endif

  logic                     adv;
  logic                     s1_valid;
  logic signed [IN_W-1:0]   s1_val [LANES];
  logic [LANES-1:0]         s1_top;

  logic signed [IN_W-1:0]   in_lane [LANES];
  logic signed [IN_W-1:0]   s1_nxt  [LANES];
  logic [LANES-1:0]         s1_top_nxt;

  logic signed [SW-1:0]     y_c [LANES];
  logic [LANES-1:0]         sat_c;
  logic [LANES-1:0]         clip_c;
  logic [LANES*OUT_W-1:0]   out_nxt;
  logic [CW1-1:0]           inc_c;
  logic [CW1-1:0]           cnt_sum;
  logic [CNT_W-1:0]         cnt_nxt;

  // Both stages advance together whenever the output register is free or draining.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    assign in_lane[g] = in_data[g*IN_W +: IN_W];
  end

  // Stage 1: apply the activation mode to each lane and flag the ReLU6 top clamp.
  always_comb begin
    s1_top_nxt = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      s1_nxt[l] = in_lane[l];
      case (in_mode)
        MODE_RELU: begin
          if (in_lane[l][IN_W-1]) s1_nxt[l] = '0;
        end
        MODE_RELU6: begin
          if (in_lane[l][IN_W-1]) begin
            s1_nxt[l] = '0;
          end else if (in_lane[l] > T_FXP) begin
            s1_nxt[l]     = T_FXP;
            s1_top_nxt[l] = 1'b1;
          end
        end
        MODE_LEAKY: begin
          if (in_lane[l][IN_W-1]) s1_nxt[l] = in_lane[l] >>> LEAK_SHIFT;
        end
        MODE_BYPASS: ;
        default: ;
      endcase
    end
  end

  // Stage 2: rescale, saturate to OUT_W, and count the clipped lanes of the beat.
  always_comb begin
    sat_c   = '0;
    out_nxt = '0;
    inc_c   = '0;
    for (int l = 0; l < int'(LANES); l++) begin
`ifdef RELU_ROUND_EN
      y_c[l] = ($signed({s1_val[l][IN_W-1], s1_val[l]}) + RND) >>> SHIFT;
`else
      y_c[l] = $signed({s1_val[l][IN_W-1], s1_val[l]}) >>> SHIFT;
`endif
      out_nxt[l*OUT_W +: OUT_W] = y_c[l][OUT_W-1:0];
      if (y_c[l] > OUT_MAX) begin
        out_nxt[l*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
        sat_c[l]                  = 1'b1;
      end else if (y_c[l] < OUT_MIN) begin
        out_nxt[l*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
        sat_c[l]                  = 1'b1;
      end
    end
    clip_c = s1_top | sat_c;
    for (int l = 0; l < int'(LANES); l++) begin
      inc_c = inc_c + CW1'(clip_c[l]);
    end
    cnt_sum = {1'b0, clip_cnt} + inc_c;
    cnt_nxt = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
  end

  // Pipeline registers and the clip counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_top    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      clip_cnt  <= '0;
      for (int l = 0; l < int'(LANES); l++) s1_val[l] <= '0;
    end else begin
      if (clr_cnt) begin
        clip_cnt <= '0;
      end else if (adv && s1_valid) begin
        clip_cnt <= cnt_nxt;
      end
      if (adv) begin
        s1_valid  <= in_valid;
        out_valid <= s1_valid;
        if (in_valid) begin
          s1_top <= s1_top_nxt;
          for (int l = 0; l < int'(LANES); l++) s1_val[l] <= s1_nxt[l];
        end
        if (s1_valid) out_data <= out_nxt;
      end
    end
  end

endmodule

// File: tb/tb_relu_act_pipe.sv
// Self-checking bench for relu_act_pipe. A single process drives stimulus and,
// on every falling edge, compares the outputs against an arithmetic reference
// model of each beat that is held in a queue. The directed literal checks pin
// down the reference model.
module tb_relu_act_pipe;

  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_mode;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [15:0]            clip_cnt;
  logic                   clr_cnt;

  always #5 clk = ~clk;

  relu_act_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clip_cnt(clip_cnt), .clr_cnt(clr_cnt)
  );

  typedef struct {
    logic [63:0] data;
    int          nclip;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  int          popped = 0;
  bit          head_seen = 0;
  bit          pend_clr = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data = '0;

  function automatic longint fdiv(input longint a, input longint b);
    longint r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  // Reference model of one beat, written with plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] mode, input logic [127:0] d);
    exp_t   e;
    longint x, v, y;
    bit     top, sat;
    e.data  = '0;
    e.nclip = 0;
    for (int l = 0; l < LANES; l++) begin
      x   = longint'($signed(d[l*32 +: 32]));
      top = 0;
      sat = 0;
      case (mode)
        2'd1:    v = (x < 0) ? 0 : x;
        2'd2:    begin
                   if (x < 0) v = 0;
                   else if (x > 6 * 32768) begin v = 6 * 32768; top = 1; end
                   else v = x;
                 end
        2'd3:    v = (x < 0) ? fdiv(x, 8) : x;
        default: v = x;
      endcase
`ifdef RELU_ROUND_EN
      y = fdiv(v + 128, 256);
`else
      y = fdiv(v, 256);
`endif
      if (y > 32767) begin y = 32767; sat = 1; end
      else if (y < -32768) begin y = -32768; sat = 1; end
      e.data[l*16 +: 16] = 16'(y);
      if (top || sat) e.nclip++;
    end
    return e;
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] pack16(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the model, then predict the coming edge.
  task automatic monitor();
    if (!rst_n) begin
      q.delete();
      exp_cnt    = 0;
      head_seen  = 0;
      pend_clr   = 0;
      prev_stall = 0;
      return;
    end
    if (pend_clr) exp_cnt = 0;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'(out_valid), 64'(0));
      end else begin
        if (!head_seen) begin
          head_seen = 1;
          if (!pend_clr) exp_cnt = (exp_cnt + q[0].nclip > 65535) ? 65535 : exp_cnt + q[0].nclip;
        end
        chk("out_data", out_data, q[0].data);
      end
    end
    chk("clip_cnt", 64'(clip_cnt), 64'(exp_cnt));
    chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (prev_stall) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data", out_data, prev_data);
    end
    pend_clr = clr_cnt;
    if (out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      head_seen = 0;
      popped++;
    end
    if (in_valid && in_ready) q.push_back(model(in_mode, in_data));
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Send one beat and check its result two cycles later.
  task automatic direct(input string name, input logic [1:0] m, input logic [127:0] d,
                        input logic [63:0] expv);
    in_valid = 1; in_mode = m; in_data = d; out_ready = 1;
    step();
    in_valid = 0;
    chk({name, "_lat1"}, 64'(out_valid), 64'(0));
    step();
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk(name, out_data, expv);
  endtask

  logic [3:0] pat = 4'b1001;
  exp_t       me;

  initial begin
    int sent, pop0, cyc;
    bit acc;
    rst_n = 0; in_valid = 1; in_mode = 2'd0; in_data = {4{32'h7FFF_FFFF}};
    out_ready = 1; clr_cnt = 0;

    // Model pinned by hand-computed results.
    me = model(2'd2, pack4(32'd32768, -32'sd32768, 32'd262144, 32'd196608));
    chk("model_relu6", me.data, pack16(128, 0, 768, 768));
    chk("model_relu6_clip", 64'(me.nclip), 64'(1));
    me = model(2'd3, pack4(-32'sd32768, 0, 0, 0));
    chk("model_leaky", me.data, pack16(-16, 0, 0, 0));

    // Reset held two cycles with in_valid high.
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_clip_cnt", 64'(clip_cnt), 64'(0));
    rst_n = 1; in_valid = 0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Mode behaviour and saturation.
    direct("relu6", 2'd2, pack4(32'd32768, -32'sd32768, 32'd262144, 32'd196608),
           pack16(128, 0, 768, 768));
    chk("relu6_clip_cnt", 64'(clip_cnt), 64'(1));
    direct("leaky", 2'd3, pack4(-32'sd32768, 0, 0, 0), pack16(-16, 0, 0, 0));
    direct("byp_max", 2'd0, pack4(32'h7FFF_FFFF, 0, 0, 0), pack16(32767, 0, 0, 0));
    chk("byp_max_clip_cnt", 64'(clip_cnt), 64'(2));
    direct("byp_min", 2'd0, pack4(32'h8000_0000, 0, 0, 0), pack16(-32768, 0, 0, 0));
    chk("byp_min_clip_cnt", 64'(clip_cnt), 64'(3));

    // Rounding boundary.
`ifdef RELU_ROUND_EN
    direct("round_384", 2'd1, pack4(32'd384, 0, 0, 0), pack16(2, 0, 0, 0));
`else
    direct("round_384", 2'd1, pack4(32'd384, 0, 0, 0), pack16(1, 0, 0, 0));
`endif
    direct("round_383", 2'd1, pack4(32'd383, 0, 0, 0), pack16(1, 0, 0, 0));

    // Reset in the middle of a stream discards in-flight beats.
    in_valid = 1; in_mode = 2'd0; in_data = {4{32'h7FFF_FFFF}};
    step();
    step();
    rst_n = 0; in_valid = 0;
    step();
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_clip", 64'(clip_cnt), 64'(0));
    rst_n = 1;
    step(); step();
    chk("midrst_after", 64'(out_valid), 64'(0));

    // Backpressure: 10 beats with mixed modes, out_ready pattern 1,0,0,1.
    sent = 0; pop0 = popped; cyc = 0;
    while ((popped - pop0) < 10 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 10);
      in_mode   = 2'(sent % 4);
      in_data   = pack4(32'(sent * 250000 - 900000), 32'(sent * 1000 + 1),
                        32'(-(sent * 40000) + 100000), 32'(sent * 300000));
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    chk("bp_beats_out", 64'(popped - pop0), 64'(10));
    step(); step();

    // Counter saturation and clear priority.
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    in_valid = 1; in_mode = 2'd0; in_data = {4{32'h7FFF_FFFF}};
    repeat (16383) step();
    in_data = pack4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0);
    step();
    in_valid = 0;
    step(); step();
    chk("cnt_fffe", 64'(clip_cnt), 64'(16'hFFFE));
    direct("cnt_beat", 2'd0, {4{32'h7FFF_FFFF}}, pack16(32767, 32767, 32767, 32767));
    chk("cnt_ffff", 64'(clip_cnt), 64'(16'hFFFF));
    direct("cnt_stick", 2'd0, {4{32'h7FFF_FFFF}}, pack16(32767, 32767, 32767, 32767));
    chk("cnt_sticky", 64'(clip_cnt), 64'(16'hFFFF));
    in_valid = 1; in_data = {4{32'h7FFF_FFFF}};
    step();
    in_valid = 0; clr_cnt = 1;
    step();
    clr_cnt = 0;
    chk("clr_prio", 64'(clip_cnt), 64'(0));
    step(); step();
    chk("clr_hold", 64'(clip_cnt), 64'(0));
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
